// File: rtl/bias_load_controller.sv
// bias_load_controller: streams one bias word into each neuron's bias memory
// (one-hot write enable), then strobes a layer-wide read and reports done once
// every memory presents its stored bias. A refresh re-strobes without reloading.
module bias_load_controller #(
    parameter int data_bits   = 16,
    parameter int num_neurons = 8,
    parameter int idx_bits    = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_load,
    input  logic                   start_refresh,
    input  logic [data_bits-1:0]   s_bias_data,
    input  logic                   s_bias_valid,
    output logic                   s_bias_ready,
    output logic [num_neurons-1:0] mem_write_en,
    output logic [data_bits-1:0]   mem_bias_in,
    output logic                   mem_read_en,
    output logic                   mem_reset,
    output logic [idx_bits-1:0]    load_idx,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        READ,
        SETTLE,
        DONE
    } state_t;

    localparam logic [idx_bits-1:0] last_idx = idx_bits'(num_neurons - 1);

    state_t state;
    logic   ready_q;
    logic   handshake;

    // Handshake decode and write steering; a reset cycle never writes a memory.
    always_comb begin
        s_bias_ready = ready_q && !reset;
        handshake    = s_bias_valid && s_bias_ready;
        mem_write_en = '0;
        mem_bias_in  = '0;
        if (handshake) begin
            mem_write_en = num_neurons'(1) << load_idx;
            mem_bias_in  = s_bias_data;
        end
    end

    // Sequencer with registered outputs: each output is set on entry to the
    // state in which it must be seen, so it is valid for exactly that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            load_idx    <= '0;
            busy        <= 1'b0;
            mem_reset   <= 1'b0;
            mem_read_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_reset   <= 1'b0;
            mem_read_en <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        mem_reset <= 1'b1;
                        load_idx  <= '0;
                    end else if (start_refresh) begin
                        state       <= READ;
                        busy        <= 1'b1;
                        mem_read_en <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= LOAD;
                    ready_q <= 1'b1;
                end
                LOAD: begin
                    if (handshake) begin
                        if (load_idx == last_idx) begin
                            load_idx    <= '0;
                            ready_q     <= 1'b0;
                            state       <= READ;
                            mem_read_en <= 1'b1;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_load_controller.sv
// Scoreboard bench for bias_load_controller: stimulus predicts the memory-side
// event sequence (clear, writes, read, done) with cycle stamps; a monitor pops
// and compares each event the DUT emits. Bias memories are emulated in the bench.
module tb_bias_load_controller;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int IB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start_load = 1'b0, start_refresh = 1'b0;
    logic [DW-1:0] s_bias_data = '0;
    logic          s_bias_valid = 1'b0;
    logic          s_bias_ready;
    logic [N-1:0]  mem_write_en;
    logic [DW-1:0] mem_bias_in;
    logic          mem_read_en, mem_reset, busy, done;
    logic [IB-1:0] load_idx;

    bias_load_controller #(.data_bits(DW), .num_neurons(N)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_refresh(start_refresh),
        .s_bias_data(s_bias_data), .s_bias_valid(s_bias_valid), .s_bias_ready(s_bias_ready),
        .mem_write_en(mem_write_en), .mem_bias_in(mem_bias_in), .mem_read_en(mem_read_en),
        .mem_reset(mem_reset), .load_idx(load_idx), .busy(busy), .done(done)
    );

    // single-neuron build
    logic          start_load1 = 1'b0, start_refresh1 = 1'b0;
    logic [DW-1:0] s_bias_data1 = '0;
    logic          s_bias_valid1 = 1'b0;
    logic          s_bias_ready1;
    logic [0:0]    mem_write_en1;
    logic [DW-1:0] mem_bias_in1;
    logic          mem_read_en1, mem_reset1, busy1, done1;
    logic [0:0]    load_idx1;

    bias_load_controller #(.data_bits(DW), .num_neurons(1)) dut1 (
        .clk(clk), .reset(reset), .start_load(start_load1), .start_refresh(start_refresh1),
        .s_bias_data(s_bias_data1), .s_bias_valid(s_bias_valid1), .s_bias_ready(s_bias_ready1),
        .mem_write_en(mem_write_en1), .mem_bias_in(mem_bias_in1), .mem_read_en(mem_read_en1),
        .mem_reset(mem_reset1), .load_idx(load_idx1), .busy(busy1), .done(done1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // emulated bias memories (clear, write, registered read)
    logic [DW-1:0] mem [N];
    logic [DW-1:0] bout [N];
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] mem1, bout1;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_reset) mem[i] <= '0;
            else if (mem_write_en[i]) mem[i] <= mem_bias_in;
            if (mem_read_en) bout[i] <= mem[i];
        end
        if (mem_reset1) mem1 <= '0;
        else if (mem_write_en1[0]) mem1 <= mem_bias_in1;
        if (mem_read_en1) bout1 <= mem1;
    end

    typedef struct {
        int            kind;  // 0 clear, 1 write, 2 read, 3 done
        int            at;
        int            idx;
        logic [DW-1:0] data;
    } ev_t;
    ev_t q[$];

    logic mon_en = 1'b0;
    logic exp_ready = 1'b0, exp_busy = 1'b0;

    task automatic got(input int kind, input int idx, input logic [DW-1:0] data);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event @cyc %0d: got kind %0d, expected none", cyc, kind);
        end else begin
            e = q.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_cycle", 64'(cyc), 64'(e.at));
            if (kind == 1 && e.kind == 1) begin
                check("write_idx", 64'(idx), 64'(e.idx));
                check("write_data", 64'(data), 64'(e.data));
            end
        end
    endtask

    // monitor: sample mid-cycle, compare emitted events against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            int widx;
            widx = -1;
            check("ready", 64'(s_bias_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(exp_busy));
            check("write_onehot", 64'($countones(mem_write_en) <= 1), 64'd1);
            check("write_exclusive", 64'((|mem_write_en) && (mem_read_en || mem_reset)), 64'd0);
            for (int i = 0; i < N; i++) if (mem_write_en[i]) widx = i;
            if (mem_reset) got(0, 0, '0);
            if (|mem_write_en) got(1, widx, mem_bias_in);
            if (mem_read_en) got(2, 0, '0);
            if (done) begin
                got(3, 0, '0);
                for (int i = 0; i < N; i++) check($sformatf("bias_out[%0d]", i), 64'(bout[i]), 64'(ref_mem[i]));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int at, input int idx, input logic [DW-1:0] data);
        ev_t e;
        e.kind = kind; e.at = at; e.idx = idx; e.data = data;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(s_bias_ready), 64'd0);
        check({tag, "_write_en"}, 64'(mem_write_en), 64'd0);
        check({tag, "_bias_in"}, 64'(mem_bias_in), 64'd0);
        check({tag, "_read_en"}, 64'(mem_read_en), 64'd0);
        check({tag, "_mem_reset"}, 64'(mem_reset), 64'd0);
        check({tag, "_load_idx"}, 64'(load_idx), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic drain(input string tag);
        check({tag, "_pending_events"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // gapmode: 0 continuous, 1 alternate cycles, 2 random; abort: reset after 3 words
    task automatic do_load(input int gapmode, input bit seq, input bit both, input bit poke, input bit abort);
        int gaps [N];
        int wt [N];
        logic [DW-1:0] w [N];
        int k, t, nw, last;
        k = cyc;
        t = k + 2;
        nw = abort ? 3 : N;
        for (int j = 0; j < N; j++) begin
            gaps[j] = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 3));
            t += gaps[j];
            wt[j] = t;
            t++;
            w[j] = seq ? DW'(16'h0010 + j) : DW'($urandom);
        end
        last = wt[N-1];
        push(0, k + 1, 0, '0);
        for (int j = 0; j < nw; j++) push(1, wt[j], j, w[j]);
        if (!abort) begin
            push(2, last + 1, 0, '0);
            push(3, last + 3, 0, '0);
        end
        for (int j = 0; j < N; j++) ref_mem[j] = (j < nw) ? w[j] : '0;

        start_load = 1'b1; start_refresh = both; s_bias_valid = 1'b0;
        exp_busy = 1'b0; exp_ready = 1'b0;
        next();
        // CLEAR: a word offered here must not be consumed
        start_load = 1'b0; start_refresh = 1'b0;
        s_bias_valid = 1'b1; s_bias_data = 16'hDEAD;
        exp_busy = 1'b1; exp_ready = 1'b0;
        next();
        exp_ready = 1'b1;
        for (int j = 0; j < nw; j++) begin
            for (int g = 0; g < gaps[j]; g++) begin
                s_bias_valid = 1'b0; s_bias_data = DW'($urandom);
                start_load = poke; start_refresh = poke;
                next();
                start_load = 1'b0; start_refresh = 1'b0;
            end
            s_bias_valid = 1'b1; s_bias_data = w[j];
            next();
        end
        if (abort) begin
            reset = 1'b1; s_bias_valid = 1'b1; s_bias_data = w[3];
            exp_ready = 1'b0;
            next();
            reset = 1'b0; s_bias_valid = 1'b0;
            exp_busy = 1'b0;
            @(negedge clk);
            check_all_zero("after_abort");
            next();
            repeat (6) next();
            drain("abort");
        end else begin
            s_bias_valid = 1'b0; exp_ready = 1'b0;
            repeat (3) next();
            exp_busy = 1'b0;
            repeat (2) next();
            drain("load");
        end
    endtask

    task automatic do_refresh();
        int k;
        k = cyc;
        push(2, k + 1, 0, '0);
        push(3, k + 3, 0, '0);
        start_refresh = 1'b1; s_bias_valid = 1'b1; s_bias_data = DW'($urandom);
        next();
        start_refresh = 1'b0;
        exp_busy = 1'b1;
        repeat (3) next();
        s_bias_valid = 1'b0; exp_busy = 1'b0;
        repeat (2) next();
        drain("refresh");
    endtask

    task automatic test_n1();
        int k, writes, wcyc, dcyc;
        k = cyc; writes = 0; wcyc = -1; dcyc = -1;
        for (int c = 0; c < 8; c++) begin
            start_load1 = (c == 0);
            s_bias_valid1 = (c >= 1);
            s_bias_data1 = (c >= 1) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
            if (mem_write_en1 !== 1'b0) begin
                writes++;
                wcyc = cyc;
                check("n1_bias_in", 64'(mem_bias_in1), 64'hBEEF);
            end
            if (done1 === 1'b1) begin
                dcyc = cyc;
                check("n1_bias_out", 64'(bout1), 64'hBEEF);
            end
            check("n1_load_idx", 64'(load_idx1), 64'd0);
            next();
        end
        start_load1 = 1'b0; s_bias_valid1 = 1'b0;
        check("n1_write_count", 64'(writes), 64'd1);
        check("n1_write_cycle", 64'(wcyc), 64'(k + 2));
        check("n1_done_cycle", 64'(dcyc), 64'(k + 5));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("n1_reset_busy", 64'(busy1), 64'd0);
        next();
        mon_en = 1'b1;
        next();

        do_load(0, 1'b1, 1'b0, 1'b0, 1'b0);   // 0x0010..0x0017, continuous
        do_refresh();
        do_load(1, 1'b0, 1'b0, 1'b1, 1'b0);   // alternate gaps with ignored starts
        do_load(0, 1'b0, 1'b1, 1'b0, 1'b0);   // both starts together
        do_load(0, 1'b0, 1'b0, 1'b0, 1'b1);   // reset after 3 words
        do_load(0, 1'b1, 1'b0, 1'b0, 1'b0);   // fresh reload after abort
        for (int r = 0; r < 3; r++) do_load(2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_refresh();
        test_n1();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
